bp_me_stream_arbiter: RTL and testbench

- Shares one BedRock memory stream port (header/data/last, ready-valid-and) among `num_req_p` stream sources, e.g. several lite-to-stream converters feeding one memory or I/O client.
- Grants are round-robin at message boundaries.
- A grant is locked from the first offered beat until the `last` beat handshakes, so multi-beat messages are never interleaved.
- Flags messages that exceed a configured beat count.

---
 rtl/bp_me_stream_arbiter_pkg.sv | 51 +++++
 rtl/bp_me_stream_rr_pick.sv | 37 +++
 rtl/bp_me_stream_arbiter.sv | 155 +++++++++++++++
 tb/tb_bp_me_stream_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_stream_arbiter_pkg.sv
// Shared types for the BedRock memory stream arbiter: processor config selector,
// the BedRock mem header layout and the arbiter state encoding.
package bp_me_stream_arbiter_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_unicore_cfg = 2'd1
  } bp_params_e;

  localparam int paddr_width_gp  = 40;
  localparam int lce_id_width_gp = 4;
  localparam int lce_assoc_gp    = 8;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef struct packed {
    logic [lce_id_width_gp-1:0]      lce_id;
    logic [$clog2(lce_assoc_gp)-1:0] way_id;
    logic [1:0]                      state;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s    payload;
    logic [2:0]                 size;
    logic [paddr_width_gp-1:0]  addr;
    logic [3:0]                 subop;
    bp_bedrock_mem_type_e       msg_type;
  } bp_bedrock_mem_header_s;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_hold = 2'd1,
    e_lock = 2'd2
  } bp_me_stream_arb_state_e;

  // Every supported config shares the same header layout today.
  function automatic int bedrock_mem_header_width_f(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return $bits(bp_bedrock_mem_header_s);
      default:          return $bits(bp_bedrock_mem_header_s);
    endcase
  endfunction

endpackage

// File: rtl/bp_me_stream_rr_pick.sv
// Round-robin picker: rotates the valid vector by the pointer, takes the lowest
// set bit and un-rotates it back into a requester index.
module bp_me_stream_rr_pick
  import bp_me_stream_arbiter_pkg::*;
#(
  parameter  int num_req_p   = 2,
  localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic [num_req_p-1:0]   v_i,
  input  logic [id_width_lp-1:0] rr_ptr_i,
  output logic [id_width_lp-1:0] id_o,
  output logic                   v_o
);

  logic [2*num_req_p-1:0] v_dbl;
  logic [num_req_p-1:0]   v_rot;
  logic [id_width_lp-1:0] off;
  logic [id_width_lp:0]   sum;

  assign v_dbl = {v_i, v_i};
  assign v_rot = num_req_p'(v_dbl >> rr_ptr_i);

  always_comb begin
    off = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      if (v_rot[k]) off = id_width_lp'(k);
    end
  end

  // Offset plus pointer, folded back into range without a modulo operator.
  assign sum  = {1'b0, off} + {1'b0, rr_ptr_i};
  assign id_o = (sum >= (id_width_lp+1)'(num_req_p))
              ? id_width_lp'(sum - (id_width_lp+1)'(num_req_p))
              : sum[id_width_lp-1:0];
  assign v_o  = |v_i;

endmodule

// File: rtl/bp_me_stream_arbiter.sv
// Shares one BedRock memory stream among num_req_p sources, round-robin at
// message boundaries, with the grant locked until the last beat handshakes.
module bp_me_stream_arbiter
  import bp_me_stream_arbiter_pkg::*;
#(
  parameter  bp_params_e bp_params_p = e_bp_default_cfg,
  parameter  int num_req_p       = 2,
  parameter  int data_width_p    = 64,
  parameter  int max_beats_p     = 8,
  localparam int header_width_lp = bedrock_mem_header_width_f(bp_params_p),
  localparam int req_id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [num_req_p*header_width_lp-1:0] mem_header_i,
  input  logic [num_req_p*data_width_p-1:0]    mem_data_i,
  input  logic [num_req_p-1:0]                 mem_v_i,
  input  logic [num_req_p-1:0]                 mem_last_i,
  output logic [num_req_p-1:0]                 mem_ready_and_o,
  output logic [header_width_lp-1:0]           mem_header_o,
  output logic [data_width_p-1:0]              mem_data_o,
  output logic                                 mem_v_o,
  input  logic                                 mem_ready_and_i,
  output logic                                 mem_last_o,
  output logic [req_id_width_lp-1:0]           grant_id_o,
  output logic                                 error_o
);

  localparam int cnt_width_lp = $clog2(max_beats_p + 1);
  localparam logic [cnt_width_lp-1:0] beat_max_lp  = cnt_width_lp'(max_beats_p);
  localparam logic [cnt_width_lp:0]   beat_lim_lp  = (cnt_width_lp+1)'(max_beats_p);

  // Handshake on any port: valid and ready both high in the same cycle.

  bp_me_stream_arb_state_e     state_q, state_d;
  logic [req_id_width_lp-1:0]  rr_ptr_q, rr_ptr_d;
  logic [req_id_width_lp-1:0]  lock_id_q, lock_id_d;
  logic [cnt_width_lp-1:0]     beat_cnt_q, beat_cnt_d;
  logic                        error_q, error_d;

  logic [req_id_width_lp-1:0]  pick_id;
  logic                        pick_v;
  logic [req_id_width_lp-1:0]  gnt_id;
  logic [num_req_p-1:0]        gnt_oh;
  logic                        sel_v;
  logic                        hs;
  logic [cnt_width_lp-1:0]     beats_prior;
  logic [cnt_width_lp:0]       beats_next;

  function automatic logic [req_id_width_lp-1:0] rr_next(input logic [req_id_width_lp-1:0] id);
    return (id == req_id_width_lp'(num_req_p - 1)) ? '0 : id + req_id_width_lp'(1);
  endfunction

  bp_me_stream_rr_pick #(
    .num_req_p(num_req_p)
  ) u_pick (
    .v_i      (mem_v_i),
    .rr_ptr_i (rr_ptr_q),
    .id_o     (pick_id),
    .v_o      (pick_v)
  );

  // Outside e_idle the grant is frozen so an offered beat cannot change under us.
  assign gnt_id = (state_q == e_idle) ? pick_id : lock_id_q;
  assign sel_v  = (state_q == e_idle) ? pick_v  : mem_v_i[lock_id_q];

  for (genvar g = 0; g < num_req_p; g++) begin : g_oh
    assign gnt_oh[g] = (gnt_id == req_id_width_lp'(g));
  end

  // One-hot AND-OR datapath mux.
  always_comb begin
    mem_header_o = '0;
    mem_data_o   = '0;
    mem_last_o   = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      mem_header_o = mem_header_o | ({header_width_lp{gnt_oh[i]}} & mem_header_i[i*header_width_lp +: header_width_lp]);
      mem_data_o   = mem_data_o   | ({data_width_p{gnt_oh[i]}}    & mem_data_i[i*data_width_p +: data_width_p]);
      mem_last_o   = mem_last_o   | (gnt_oh[i] & mem_last_i[i]);
    end
  end

  assign mem_v_o         = reset_n_i & sel_v;
  assign mem_ready_and_o = {num_req_p{reset_n_i & mem_ready_and_i}} & gnt_oh;
  assign grant_id_o      = reset_n_i ? gnt_id : '0;
  assign error_o         = error_q;
  assign hs              = mem_v_o & mem_ready_and_i;

  // Beats already accepted in this message; the first beat always lands outside e_lock.
  assign beats_prior = (state_q == e_lock) ? beat_cnt_q : cnt_width_lp'(0);
  assign beats_next  = {1'b0, beats_prior} + (cnt_width_lp+1)'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_id_d  = lock_id_q;
    beat_cnt_d = beat_cnt_q;
    error_d    = error_q;

    if (hs && !mem_last_o && (beats_next >= beat_lim_lp)) error_d = 1'b1;

    case (state_q)
      e_idle: begin
        if (mem_v_o) begin
          if (hs && mem_last_o) begin
            rr_ptr_d = rr_next(gnt_id);
          end else if (hs) begin
            state_d    = e_lock;
            lock_id_d  = gnt_id;
            beat_cnt_d = cnt_width_lp'(1);
          end else begin
            state_d    = e_hold;
            lock_id_d  = gnt_id;
          end
        end
      end
      e_hold: begin
        if (hs && mem_last_o) begin
          state_d  = e_idle;
          rr_ptr_d = rr_next(lock_id_q);
        end else if (hs) begin
          state_d    = e_lock;
          beat_cnt_d = cnt_width_lp'(1);
        end
      end
      e_lock: begin
        if (hs && mem_last_o) begin
          state_d    = e_idle;
          rr_ptr_d   = rr_next(lock_id_q);
          beat_cnt_d = '0;
        end else if (hs && (beat_cnt_q != beat_max_lp)) begin
          beat_cnt_d = beat_cnt_q + cnt_width_lp'(1);
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_idle;
      rr_ptr_q   <= '0;
      lock_id_q  <= '0;
      beat_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_id_q  <= lock_id_d;
      beat_cnt_q <= beat_cnt_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_bp_me_stream_arbiter.sv
// Bench for bp_me_stream_arbiter: per-requester drivers push expected beats,
// a negedge monitor checks every offered beat against a message-level model.
module tb_bp_me_stream_arbiter;
  import bp_me_stream_arbiter_pkg::*;

  localparam int N    = 3;
  localparam int DW   = 64;
  localparam int MAXB = 8;
  localparam int HW   = bedrock_mem_header_width_f(e_bp_default_cfg);
  localparam int IW   = 2;
  localparam int BW   = HW + DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [N*HW-1:0] mem_header_i;
  logic [N*DW-1:0] mem_data_i;
  logic [N-1:0]    mem_v_i, mem_last_i, mem_ready_and_o;
  logic [HW-1:0]   mem_header_o;
  logic [DW-1:0]   mem_data_o;
  logic            mem_v_o, mem_ready_and_i, mem_last_o, error_o;
  logic [IW-1:0]   grant_id_o;

  logic [HW-1:0] drv_hdr [N];
  logic [DW-1:0] drv_data[N];
  logic [N-1:0]  drv_v, drv_last;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign mem_header_i[g*HW +: HW] = drv_hdr[g];
    assign mem_data_i[g*DW +: DW]   = drv_data[g];
  end
  assign mem_v_i    = drv_v;
  assign mem_last_i = drv_last;

  bp_me_stream_arbiter #(
    .bp_params_p  (e_bp_default_cfg),
    .num_req_p    (N),
    .data_width_p (DW),
    .max_beats_p  (MAXB)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .mem_header_i    (mem_header_i),
    .mem_data_i      (mem_data_i),
    .mem_v_i         (mem_v_i),
    .mem_last_i      (mem_last_i),
    .mem_ready_and_o (mem_ready_and_o),
    .mem_header_o    (mem_header_o),
    .mem_data_o      (mem_data_o),
    .mem_v_o         (mem_v_o),
    .mem_ready_and_i (mem_ready_and_i),
    .mem_last_o      (mem_last_o),
    .grant_id_o      (grant_id_o),
    .error_o         (error_o)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [BW-1:0] exp_q[N][$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Message-level model: a requester owns the port from its first offered beat
  // until its last beat is accepted; the next owner is the first valid
  // requester at or after the one following the previous owner.
  int            owner = -1;
  int            rr_m  = 0;
  logic          err_exp = 1'b0;
  int            beat_in_msg[N];
  int            waiting[N];
  int            m_eo;
  logic          m_ev;
  logic [N-1:0]  m_rdy;
  logic [BW-1:0] m_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        exp_q[r].delete();
        beat_in_msg[r] = 0;
        waiting[r]     = 0;
      end
      owner   = -1;
      rr_m    = 0;
      err_exp = 1'b0;
      check("rst_mem_v_o", 128'(mem_v_o), 128'(0));
      check("rst_ready_and_o", 128'(mem_ready_and_o), 128'(0));
      check("rst_grant_id_o", 128'(grant_id_o), 128'(0));
      check("rst_error_o", 128'(error_o), 128'(0));
    end else begin
      check("error_o", 128'(error_o), 128'(err_exp));
      m_eo = -1;
      if (owner >= 0) m_eo = owner;
      else begin
        for (int k = 0; k < N; k++)
          if (m_eo < 0 && drv_v[(rr_m + k) % N]) m_eo = (rr_m + k) % N;
      end
      m_ev = 1'b0;
      if (m_eo >= 0) m_ev = drv_v[m_eo];
      check("mem_v_o", 128'(mem_v_o), 128'(m_ev));
      if (m_eo >= 0) begin
        m_rdy = '0;
        m_rdy[m_eo] = mem_ready_and_i;
        check("ready_and_o", 128'(mem_ready_and_o), 128'(m_rdy));
      end
      if (m_ev) begin
        owner = m_eo;
        check("grant_id_o", 128'(grant_id_o), 128'(m_eo));
        if (exp_q[m_eo].size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_q: got beat %0h from req %0d, expected no pending beat", mem_data_o, m_eo);
        end else begin
          check("beat", 128'({mem_header_o, mem_data_o, mem_last_o}), 128'(exp_q[m_eo][0]));
          if (mem_ready_and_i) begin
            m_w = exp_q[m_eo].pop_front();
            beat_in_msg[m_eo]++;
            if (m_w[0]) begin
              for (int j = 0; j < N; j++) begin
                if (j != m_eo && drv_v[j]) begin
                  waiting[j]++;
                  check("fairness", 128'(waiting[j] > N - 1), 128'(0));
                end
              end
              waiting[m_eo]     = 0;
              beat_in_msg[m_eo] = 0;
              owner             = -1;
              rr_m              = (m_eo + 1) % N;
            end else if (beat_in_msg[m_eo] >= MAXB) begin
              err_exp = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  int seq_ctr = 0;

  task automatic present(input int r, input logic last);
    logic [HW-1:0] h;
    logic [DW-1:0] d;
    h = HW'({$urandom(), $urandom()});
    d = {8'(r), 24'(seq_ctr), $urandom()};
    seq_ctr++;
    drv_hdr[r]  = h;
    drv_data[r] = d;
    drv_last[r] = last;
    drv_v[r]    = 1'b1;
    exp_q[r].push_back({h, d, last});
  endtask

  task automatic wait_hs(input int r);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (mem_ready_and_o[r]) break;
      n++;
      if (n > 5000) begin
        total++;
        bad++;
        $display("FAIL hs_timeout: req %0d ready stayed 0 for %0d cycles, expected 1", r, n);
        break;
      end
    end
    @(posedge clk);
    #1;
    drv_v[r] = 1'b0;
  endtask

  task automatic send_msg(input int r, input int len, input int max_gap);
    int gap;
    for (int b = 0; b < len; b++) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      present(r, b == len - 1);
      wait_hs(r);
    end
  endtask

  task automatic rand_src(input int r);
    int len;
    repeat (25) begin
      len = ($urandom_range(0, 9) == 0) ? MAXB + 1 : $urandom_range(1, MAXB);
      send_msg(r, len, 2);
    end
  endtask

  logic rand_rdy = 1'b0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      mem_ready_and_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time %0t reached, expected completion earlier", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  int t0;
  initial begin
    rst_n = 1'b0;
    mem_ready_and_i = 1'b0;
    drv_v = '0;
    drv_last = '0;
    for (int r = 0; r < N; r++) begin
      drv_hdr[r]  = '0;
      drv_data[r] = '0;
    end
    repeat (3) @(posedge clk);
    check("rst_state", 128'(dut.state_q), 128'(e_idle));
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requester, full throughput.
    mem_ready_and_i = 1'b1;
    t0 = cyc;
    send_msg(1, 4, 0);
    check("single_cycles", 128'(cyc - t0), 128'(4));
    check("rr_after_single", 128'(dut.rr_ptr_q), 128'(2));

    // Contention: pointer at 2 so req 2 goes first, then wrap to req 0, no bubble.
    t0 = cyc;
    fork
      send_msg(0, 2, 0);
      send_msg(2, 2, 0);
    join
    check("contention_cycles", 128'(cyc - t0), 128'(4));
    fork
      send_msg(0, 2, 0);
      send_msg(1, 2, 0);
    join

    // Hold: req 1 offered under back-pressure, req 0 arrives a cycle later.
    mem_ready_and_i = 1'b0;
    fork
      send_msg(1, 2, 0);
      begin
        @(posedge clk);
        #1;
        send_msg(0, 1, 0);
      end
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        mem_ready_and_i = 1'b1;
      end
    join

    // Overflow: nine beats against a limit of eight.
    send_msg(2, MAXB + 1, 0);
    check("error_after_overflow", 128'(error_o), 128'(1));
    send_msg(0, 1, 0);
    check("error_sticky", 128'(error_o), 128'(1));

    // Asynchronous reset in the middle of beat 2.
    present(0, 1'b0);
    wait_hs(0);
    present(0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_mem_v_o", 128'(mem_v_o), 128'(0));
    check("async_ready_and_o", 128'(mem_ready_and_o), 128'(0));
    check("async_error_o", 128'(error_o), 128'(0));
    check("async_state", 128'(dut.state_q), 128'(e_idle));
    drv_v[0] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    fork
      send_msg(2, 1, 0);
      send_msg(1, 2, 0);
    join
    check("error_after_reset", 128'(error_o), 128'(0));

    // Random traffic with random back-pressure.
    rand_rdy = 1'b1;
    fork
      rand_src(0);
      rand_src(1);
      rand_src(2);
    join
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) check("queue_drained", 128'(exp_q[r].size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
